// File: rtl/exec_sequencer.sv
// Multi-cycle fetch/decode/memory/execute sequencer for the 16-bit accumulator CPU.
// Owns the PC, the instruction register and the CALL/RET return stack.
module exec_sequencer #(
    parameter int DEPTH = 8,
    parameter int PC_W  = 10
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [15:0]     inst,
    input  logic [1:0]      data_src,
    input  logic [PC_W-1:0] operand,
    input  logic            ce_reg,
    input  logic            ce_mem,
    input  logic            ce_a,
    input  logic            ce_cy,
    input  logic            ce_bank,
    input  logic            is_jump,
    input  logic            call,
    input  logic            ret,
    input  logic            jump_taken,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ready,
    output logic            we_reg,
    output logic            we_a,
    output logic            we_cy,
    output logic            we_bank,
    output logic [PC_W-1:0] pc,
    output logic            halted,
    output logic            err_ovf,
    output logic            err_unf,
    output logic [15:0]     retired
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_MEM,
        S_EXEC,
        S_HALT
    } state_t;

    state_t            state_reg, state_next;
    logic [PC_W-1:0]   pc_reg, pc_next, pc_plus1;
    logic [15:0]       inst_reg;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic [15:0]       retired_reg;
    logic              ovf_reg, unf_reg;
    logic              set_ovf, set_unf;
    logic              exec_ok, push_en, needs_mem;
    logic              stack_full, stack_empty;
    logic [IDX_W-1:0]  top_idx;
    logic [PC_W-1:0]   top_reg;
    logic [PC_W-1:0]   stack_mem [DEPTH];
    logic [3:0]        ce_vec, we_vec;

    assign pc_plus1    = pc_reg + PC_W'(1);
    assign stack_full  = (count_reg == CNT_W'(DEPTH));
    assign stack_empty = (count_reg == '0);
    assign top_idx     = stack_empty ? '0 : IDX_W'(count_reg - CNT_W'(1));
    // ADDR and [Rx] operands go through data memory; #DATA and Rx do not
    assign needs_mem   = (ce_a | ce_mem) & ((data_src == 2'b00) | (data_src == 2'b10));

    always_comb begin
        state_next = state_reg;
        pc_next    = pc_reg;
        count_next = count_reg;
        push_en    = 1'b0;
        exec_ok    = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state_reg)
            S_FETCH:  if (imem_valid) state_next = S_DECODE;
            S_DECODE: state_next = needs_mem ? S_MEM : S_EXEC;
            S_MEM:    if (dmem_ready) state_next = S_EXEC;
            S_EXEC: begin
                state_next = S_FETCH;
                if (ret) begin
                    if (stack_empty) begin
                        set_unf    = 1'b1;
                        state_next = S_HALT;
                    end else begin
                        pc_next    = top_reg;
                        count_next = count_reg - CNT_W'(1);
                        exec_ok    = 1'b1;
                    end
                end else if (call) begin
                    if (stack_full) begin
                        set_ovf    = 1'b1;
                        state_next = S_HALT;
                    end else begin
                        push_en    = 1'b1;
                        pc_next    = operand;
                        count_next = count_reg + CNT_W'(1);
                        exec_ok    = 1'b1;
                    end
                end else begin
                    pc_next = (is_jump & jump_taken) ? operand : pc_plus1;
                    exec_ok = 1'b1;
                end
            end
            S_HALT:   state_next = S_HALT;
            default:  state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            pc_reg      <= '0;
            inst_reg    <= '0;
            count_reg   <= '0;
            retired_reg <= '0;
            ovf_reg     <= 1'b0;
            unf_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
            count_reg <= count_next;
            if (state_reg == S_FETCH && imem_valid) inst_reg <= imem_rdata;
            if (exec_ok) retired_reg <= retired_reg + 16'd1;
            ovf_reg <= ovf_reg | set_ovf;
            unf_reg <= unf_reg | set_unf;
        end
    end

    // Top-of-stack is read every cycle; it is stable by EXEC because pushes only happen in EXEC
    always_ff @(posedge clk) begin
        if (push_en && !rst) stack_mem[IDX_W'(count_reg)] <= pc_plus1;
        top_reg <= stack_mem[top_idx];
    end

    assign ce_vec = {ce_bank, ce_cy, ce_a, ce_reg};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_we
            assign we_vec[gi] = exec_ok & ce_vec[gi];
        end
    endgenerate

    assign {we_bank, we_cy, we_a, we_reg} = we_vec;
    assign imem_req  = (state_reg == S_FETCH);
    assign imem_addr = pc_reg;
    assign dmem_req  = (state_reg == S_MEM);
    assign dmem_we   = dmem_req & ce_mem;
    assign halted    = (state_reg == S_HALT);
    assign inst      = inst_reg;
    assign pc        = pc_reg;
    assign err_ovf   = ovf_reg;
    assign err_unf   = unf_reg;
    assign retired   = retired_reg;

endmodule
